// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set request after 'last', wrapping; 'last' itself has lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        win = last;
        for (int i = N_REQ; i > 0; i--) begin
            idx = last + IDX_W'(i);
            if (req[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Requester-side bundle: request/release in, decoder select and grant out.
interface decoder_rr_arbiter_if
    import arb_pkg::*;
();
    logic [N_REQ-1:0] req;
    logic             done;
    logic             dec_en;
    logic [IDX_W-1:0] dec_a;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    modport master (output req, done,
                    input  dec_en, dec_a, grant, busy, timeout);

    modport slave  (input  req, done,
                    output dec_en, dec_a, grant, busy, timeout);
endinterface

// File: rtl/decoder_3_8.sv
// 3-to-8 one-hot decoder with enable; all-zero when disabled.
module decoder_3_8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] bcode
);
    always_comb begin
        bcode = 8'd0;
        if (en) bcode = 8'd1 << a;
    end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner selection driving a 3-to-8 decoder, with handshake or
// timeout release and a one-cycle dead gap between owners.
module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_rr_arbiter_if.slave bus_io
);

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_q,    state_d;
    logic             dec_en_q,   dec_en_d;
    logic [IDX_W-1:0] dec_a_q,    dec_a_d;
    logic [IDX_W-1:0] last_q,     last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;
    logic             busy_q,     busy_d;
    logic [N_REQ-1:0] grant_c;

    logic hold_hit_c;
    logic owner_req_c;
    logic release_c;

    assign hold_hit_c  = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    assign owner_req_c = bus_io.req[dec_a_q];
    assign release_c   = bus_io.done || !owner_req_c || hold_hit_c;

    always_comb begin
        state_d    = state_q;
        dec_en_d   = dec_en_q;
        dec_a_d    = dec_a_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus_io.req) begin
                    state_d    = GRANT;
                    dec_en_d   = 1'b1;
                    dec_a_d    = rr_pick(bus_io.req, last_q);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (hold_cnt_q != {CNT_W{1'b1}}) hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (release_c) begin
                    state_d   = GAP;
                    dec_en_d  = 1'b0;
                    last_d    = dec_a_q;
                    // Timeout flagged only when the hold limit alone forces release.
                    timeout_d = hold_hit_c && !bus_io.done && owner_req_c;
                end
            end
            GAP: begin
                if (|bus_io.req) begin
                    state_d    = GRANT;
                    dec_en_d   = 1'b1;
                    dec_a_d    = rr_pick(bus_io.req, last_q);
                    hold_cnt_d = '0;
                end else begin
                    state_d  = IDLE;
                    dec_en_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                dec_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dec_en_q   <= 1'b0;
            dec_a_q    <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dec_en_q   <= dec_en_d;
            dec_a_q    <= dec_a_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    decoder_3_8 u_dec (
        .en    (dec_en_q),
        .a     (dec_a_q),
        .bcode (grant_c)
    );

    assign bus_io.dec_en  = dec_en_q;
    assign bus_io.dec_a   = dec_a_q;
    assign bus_io.grant   = grant_c;
    assign bus_io.busy    = busy_q;
    assign bus_io.timeout = timeout_q;

endmodule
